// File: rtl/vga_fb_scan_pkg.sv
// Shared definitions for the VGA framebuffer scanner.
// Holds the default 640x480@60 timing, counter/address/colour types,
// the display-region enum with its transition function, and the RGB
// field slicing helpers.
package vga_fb_scan_pkg;

   localparam int unsigned CNT_W  = 10;
   localparam int unsigned ADDR_W = 15;
   localparam int unsigned RGB_W  = 12;

   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [RGB_W-1:0]  rgb_t;

   typedef enum logic [1:0] {RegActive, RegFront, RegSync, RegBack} region_e;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   // Region entered after leaving position pos; each end_* is the last
   // position of the named region.
   function automatic region_e region_next(region_e cur, cnt_t pos, cnt_t end_act,
                                           cnt_t end_fp, cnt_t end_sync, cnt_t end_tot);
      region_e nxt;
      nxt = cur;
      case (cur)
         RegActive: if (pos == end_act)  nxt = RegFront;
         RegFront:  if (pos == end_fp)   nxt = RegSync;
         RegSync:   if (pos == end_sync) nxt = RegBack;
         RegBack:   if (pos == end_tot)  nxt = RegActive;
         default:   nxt = RegActive;
      endcase
      return nxt;
   endfunction

   function automatic logic [3:0] rgb_r(rgb_t c);
      return c[11:8];
   endfunction

   function automatic logic [3:0] rgb_g(rgb_t c);
      return c[7:4];
   endfunction

   function automatic logic [3:0] rgb_b(rgb_t c);
      return c[3:0];
   endfunction

endpackage

// File: rtl/vga_fb_scan_if.sv
// Framebuffer read port plus VGA pin bundle.
//   fb_addr     : framebuffer read address (scanner -> memory)
//   fb_data     : 12-bit RGB read data, one clk after fb_addr (memory -> scanner)
//   vga_r/g/b   : 4-bit colour pins
//   vga_hs/vs   : sync pins
//   frame_start : one-clk pulse at the start of each frame
// master = scanner side, slave = memory/board side.
interface vga_fb_scan_if;
   import vga_fb_scan_pkg::*;

   addr_t      fb_addr;
   rgb_t       fb_data;
   logic [3:0] vga_r;
   logic [3:0] vga_g;
   logic [3:0] vga_b;
   logic       vga_hs;
   logic       vga_vs;
   logic       frame_start;

   modport master (
      output fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start,
      input  fb_data
   );

   modport slave (
      input  fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start,
      output fb_data
   );

endinterface

// File: rtl/vga_fb_scan_timing.sv
// VGA timing core: pixel-tick divider, h/v counters, region FSMs.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   o_tick          : one clk in CLK_DIV, counters advance on it
//   o_h, o_v        : current pixel position
//   o_hsync/o_vsync : high while in the sync region (polarity applied by caller)
//   o_active        : both regions active
//   o_frame_start   : one-clk pulse on the clk after the counters wrap to (0,0)
module vga_fb_scan_timing
   import vga_fb_scan_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick,
   output cnt_t o_h,
   output cnt_t o_v,
   output logic o_hsync,
   output logic o_vsync,
   output logic o_active,
   output logic o_frame_start
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam cnt_t H_END_ACT  = cnt_t'(H_ACTIVE - 1);
   localparam cnt_t H_END_FP   = cnt_t'(H_ACTIVE + H_FP - 1);
   localparam cnt_t H_END_SYNC = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam cnt_t H_END_TOT  = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t V_END_ACT  = cnt_t'(V_ACTIVE - 1);
   localparam cnt_t V_END_FP   = cnt_t'(V_ACTIVE + V_FP - 1);
   localparam cnt_t V_END_SYNC = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam cnt_t V_END_TOT  = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [DIV_W-1:0] r_div;
   cnt_t             r_h;
   cnt_t             r_v;
   region_e          r_hreg;
   region_e          r_vreg;
   logic             r_frame_start;

   logic w_tick;
   logic w_line_end;
   logic w_frame_end;

   assign w_tick      = (r_div == DIV_LAST);
   assign w_line_end  = w_tick && (r_h == H_END_TOT);
   assign w_frame_end = w_line_end && (r_v == V_END_TOT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div         <= '0;
         r_h           <= '0;
         r_v           <= '0;
         r_hreg        <= RegActive;
         r_vreg        <= RegActive;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_frame_end;
         r_div         <= w_tick ? '0 : r_div + 1'b1;
         if (w_tick) begin
            r_h    <= w_line_end ? '0 : r_h + 1'b1;
            r_hreg <= region_next(r_hreg, r_h, H_END_ACT, H_END_FP, H_END_SYNC, H_END_TOT);
            if (w_line_end) begin
               r_v    <= w_frame_end ? '0 : r_v + 1'b1;
               r_vreg <= region_next(r_vreg, r_v, V_END_ACT, V_END_FP, V_END_SYNC, V_END_TOT);
            end
         end
      end
   end

   assign o_tick        = w_tick;
   assign o_h           = r_h;
   assign o_v           = r_v;
   assign o_hsync       = (r_hreg == RegSync);
   assign o_vsync       = (r_vreg == RegSync);
   assign o_active      = (r_hreg == RegActive) && (r_vreg == RegActive);
   assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_fb_scan.sv
// Display-side framebuffer reader. Walks an IMG_W x IMG_H image in raster
// order, replicating each pixel SCALE x SCALE, centred in the active area
// with BORDER_RGB around it, and drives 4:4:4 VGA pins.
// IMG_W*SCALE must fit H_ACTIVE, IMG_H*SCALE must fit V_ACTIVE, and the
// framebuffer read latency (1 clk) must be below CLK_DIV.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   io_bus   : master side of vga_fb_scan_if (fb_addr/fb_data, VGA pins, frame_start)
module vga_fb_scan
   import vga_fb_scan_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned H_FP       = H_FP_DEF,
   parameter int unsigned H_SYNC     = H_SYNC_DEF,
   parameter int unsigned H_BP       = H_BP_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned V_FP       = V_FP_DEF,
   parameter int unsigned V_SYNC     = V_SYNC_DEF,
   parameter int unsigned V_BP       = V_BP_DEF,
   parameter int unsigned IMG_W      = 200,
   parameter int unsigned IMG_H      = 150,
   parameter int unsigned SCALE      = 3,
   parameter rgb_t        BORDER_RGB = 12'h000,
   parameter bit          SYNC_POL   = 1'b0
) (
   input logic           clk,
   input logic           rst,
   vga_fb_scan_if.master io_bus
);

   localparam cnt_t X0        = cnt_t'((H_ACTIVE - IMG_W * SCALE) / 2);
   localparam cnt_t X_LAST    = cnt_t'((H_ACTIVE - IMG_W * SCALE) / 2 + IMG_W * SCALE - 1);
   localparam cnt_t Y0        = cnt_t'((V_ACTIVE - IMG_H * SCALE) / 2);
   localparam cnt_t Y_LAST    = cnt_t'((V_ACTIVE - IMG_H * SCALE) / 2 + IMG_H * SCALE - 1);
   localparam cnt_t H_END_TOT = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t V_END_TOT = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam int unsigned SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
   localparam addr_t ROW_STEP = addr_t'(IMG_W);

   logic w_tick;
   cnt_t w_h;
   cnt_t w_v;
   logic w_hsync;
   logic w_vsync;
   logic w_active;
   logic w_frame_start;

   vga_fb_scan_timing #(
      .CLK_DIV  (CLK_DIV),
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk           (clk),
      .rst           (rst),
      .o_tick        (w_tick),
      .o_h           (w_h),
      .o_v           (w_v),
      .o_hsync       (w_hsync),
      .o_vsync       (w_vsync),
      .o_active      (w_active),
      .o_frame_start (w_frame_start)
   );

   logic w_row_in;
   logic w_in_win;
   logic w_line_end;

   assign w_row_in   = (w_v >= Y0) && (w_v <= Y_LAST);
   assign w_in_win   = w_row_in && (w_h >= X0) && (w_h <= X_LAST);
   assign w_line_end = w_tick && (w_h == H_END_TOT);

   logic [SUB_W-1:0] r_hsub;
   logic [SUB_W-1:0] r_vsub;
   addr_t            r_col;
   addr_t            r_row_base;
   addr_t            r_addr;
   // Stage 1 carries per-pixel attributes alongside the address in flight.
   logic             r_in_win_d;
   logic             r_active_d;
   logic             r_hs_d;
   logic             r_vs_d;
   rgb_t             r_rgb;
   logic             r_hs;
   logic             r_vs;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hsub     <= '0;
         r_vsub     <= '0;
         r_col      <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
         r_in_win_d <= 1'b0;
         r_active_d <= 1'b0;
         r_hs_d     <= 1'b0;
         r_vs_d     <= 1'b0;
         r_rgb      <= '0;
         r_hs       <= ~SYNC_POL;
         r_vs       <= ~SYNC_POL;
      end else if (w_tick) begin
         r_in_win_d <= w_in_win;
         r_active_d <= w_active;
         r_hs_d     <= w_hsync;
         r_vs_d     <= w_vsync;

         // Address only moves inside the window; it holds elsewhere.
         if (w_in_win) begin
            r_addr <= r_row_base + r_col;
            if (w_h == X_LAST) begin
               r_hsub <= '0;
               r_col  <= '0;
            end else if (r_hsub == SUB_LAST) begin
               r_hsub <= '0;
               r_col  <= r_col + 1'b1;
            end else begin
               r_hsub <= r_hsub + 1'b1;
            end
         end

         if (w_line_end) begin
            if (w_v == V_END_TOT) begin
               r_vsub     <= '0;
               r_row_base <= '0;
            end else if (w_row_in) begin
               if (r_vsub == SUB_LAST) begin
                  r_vsub     <= '0;
                  // Clear after the last image row so row_base never passes the image.
                  r_row_base <= (w_v == Y_LAST) ? '0 : r_row_base + ROW_STEP;
               end else begin
                  r_vsub <= r_vsub + 1'b1;
               end
            end
         end

         // fb_data now reflects the address issued one tick earlier.
         r_rgb <= !r_active_d ? '0 : (r_in_win_d ? io_bus.fb_data : BORDER_RGB);
         r_hs  <= r_hs_d ? SYNC_POL : ~SYNC_POL;
         r_vs  <= r_vs_d ? SYNC_POL : ~SYNC_POL;
      end
   end

   assign io_bus.fb_addr     = r_addr;
   assign io_bus.vga_r       = rgb_r(r_rgb);
   assign io_bus.vga_g       = rgb_g(r_rgb);
   assign io_bus.vga_b       = rgb_b(r_rgb);
   assign io_bus.vga_hs      = r_hs;
   assign io_bus.vga_vs      = r_vs;
   assign io_bus.frame_start = w_frame_start;

endmodule
